// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control FSM and the RV32I datapath.
// The FSM (master) drives strobes and selects; the datapath (slave) supplies the instruction.
interface multicycle_control_unit_if;
  logic [31:0] instrCode;
  logic        regFileWe;
  logic [3:0]  aluControl;
  logic        aluSrcMuxSel;
  logic [2:0]  RFWDSrcMuxSel;
  logic        branch;
  logic        jal;
  logic        jalr;
  logic        pcEn;
  logic        dataWe;

  modport master (
    input  instrCode,
    output regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
    output branch, jal, jalr, pcEn, dataWe
  );

  modport slave (
    output instrCode,
    input  regFileWe, aluControl, aluSrcMuxSel, RFWDSrcMuxSel,
    input  branch, jal, jalr, pcEn, dataWe
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath strobe as a decode of the current state and instruction.
//
// state  | meaning
// FETCH  | PC loads execute-stage next-PC
// DECODE | decode regs capture RF data and immediate
// R_EXE  | register-register ALU op, write back ALU result
// I_EXE  | register-immediate ALU op, write back ALU result
// B_EXE  | branch compare, next-PC reg captures target or PC+4
// LU_EXE | LUI, write back immediate
// AU_EXE | AUIPC, write back PC+imm
// J_EXE  | JAL, link PC+4, target PC+imm
// JL_EXE | JALR, link PC+4, target rs1+imm
// S_EXE  | store address rs1+imm
// S_MEM  | data-memory write strobe
// L_EXE  | load address rs1+imm
// L_MEM  | memory read, mem-read reg captures
// L_WB   | write back mem-read reg
module multicycle_control_unit (
  input  logic                            clk,
  input  logic                            reset,
  multicycle_control_unit_if.master       ctrl_if
);

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE,
    J_EXE, JL_EXE, S_EXE, S_MEM, L_EXE, L_MEM, L_WB
  } state_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  state_e      state_q;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        instr30;
  logic        unused_instr_bits;

  assign opcode            = ctrl_if.instrCode[6:0];
  assign funct3            = ctrl_if.instrCode[14:12];
  assign instr30           = ctrl_if.instrCode[30];
  assign unused_instr_bits = ^{ctrl_if.instrCode[31], ctrl_if.instrCode[29:15],
                               ctrl_if.instrCode[11:7]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:  state_q <= DECODE;
        DECODE: begin
          case (opcode)
            OP_R:    state_q <= R_EXE;
            OP_I:    state_q <= I_EXE;
            OP_B:    state_q <= B_EXE;
            OP_LU:   state_q <= LU_EXE;
            OP_AU:   state_q <= AU_EXE;
            OP_J:    state_q <= J_EXE;
            OP_JL:   state_q <= JL_EXE;
            OP_S:    state_q <= S_EXE;
            OP_L:    state_q <= L_EXE;
            default: state_q <= FETCH;
          endcase
        end
        S_EXE:   state_q <= S_MEM;
        L_EXE:   state_q <= L_MEM;
        L_MEM:   state_q <= L_WB;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Strobes are combinational so the datapath sees them in the same cycle;
  // reset forces them low even before the state register has settled.
  always_comb begin
    ctrl_if.regFileWe     = 1'b0;
    ctrl_if.aluControl    = 4'b0000;
    ctrl_if.aluSrcMuxSel  = 1'b0;
    ctrl_if.RFWDSrcMuxSel = 3'd0;
    ctrl_if.branch        = 1'b0;
    ctrl_if.jal           = 1'b0;
    ctrl_if.jalr          = 1'b0;
    ctrl_if.pcEn          = 1'b0;
    ctrl_if.dataWe        = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: ctrl_if.pcEn = 1'b1;
        R_EXE: begin
          ctrl_if.regFileWe  = 1'b1;
          ctrl_if.aluControl = {instr30, funct3};
        end
        I_EXE: begin
          ctrl_if.aluSrcMuxSel = 1'b1;
          ctrl_if.regFileWe    = 1'b1;
          // Only shifts use bit 30 (SRLI/SRAI); elsewhere it is immediate data.
          ctrl_if.aluControl   = (funct3 == 3'b101) ? {instr30, funct3} : {1'b0, funct3};
        end
        B_EXE: begin
          ctrl_if.branch     = 1'b1;
          ctrl_if.aluControl = {1'b0, funct3};
        end
        LU_EXE: begin
          ctrl_if.regFileWe     = 1'b1;
          ctrl_if.RFWDSrcMuxSel = 3'd2;
        end
        AU_EXE: begin
          ctrl_if.regFileWe     = 1'b1;
          ctrl_if.RFWDSrcMuxSel = 3'd3;
        end
        J_EXE: begin
          ctrl_if.jal           = 1'b1;
          ctrl_if.regFileWe     = 1'b1;
          ctrl_if.RFWDSrcMuxSel = 3'd4;
        end
        JL_EXE: begin
          ctrl_if.jal           = 1'b1;
          ctrl_if.jalr          = 1'b1;
          ctrl_if.regFileWe     = 1'b1;
          ctrl_if.RFWDSrcMuxSel = 3'd4;
        end
        S_EXE:  ctrl_if.aluSrcMuxSel = 1'b1;
        S_MEM:  ctrl_if.dataWe       = 1'b1;
        L_EXE:  ctrl_if.aluSrcMuxSel = 1'b1;
        L_WB: begin
          ctrl_if.regFileWe     = 1'b1;
          ctrl_if.RFWDSrcMuxSel = 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
